// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration register bank: header field
// positions, frame-state encoding, size limits and the pointer-wrap helper.
// Optional feature macro used by the bank: SPI_CFG_READBACK_EN.
package spi_cfg_pkg;

  localparam int unsigned HDR_RW_BIT   = 7;
  localparam int unsigned HDR_ADDR_LSB = 0;
  localparam int unsigned HDR_ADDR_W   = 4;
  localparam int unsigned MAX_REGS     = 16;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned BIT_CNT_W    = 3;

  typedef enum logic [1:0] {
    HDR,
    WR,
    RD,
    IGNORE
  } frame_state_e;

  // Address pointer advance with wrap at the last implemented register.
  function automatic logic [HDR_ADDR_W-1:0] ptr_next(input logic [HDR_ADDR_W-1:0] p,
                                                     input int unsigned n);
    return (32'(p) == n - 1) ? '0 : p + HDR_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// Serial-to-byte receiver: 3-bit bit counter plus rx shifter.
// Ports:
//   SCLK, rst_n (sync, active-low), SSEL (active-low select), MOSI (MSB first)
//   rx_byte_c   : byte being completed on this edge (shifter plus live MOSI)
//   byte_done_c : high on the 8th sampling edge of a byte
// Frame state clears on any edge with SSEL high or rst_n low.
module spi_byte_rx
  import spi_cfg_pkg::*;
(
  input  logic              SCLK,
  input  logic              rst_n,
  input  logic              SSEL,
  input  logic              MOSI,
  output logic [BYTE_W-1:0] rx_byte_c,
  output logic              byte_done_c
);

  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BYTE_W-2:0]    shift;

  // Bit counter wraps 7 -> 0, so each byte boundary needs no extra clear.
  always_ff @(posedge SCLK) begin
    if (!rst_n || SSEL) begin
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      shift   <= {shift[BYTE_W-3:0], MOSI};
    end
  end

  // The completing bit is still on MOSI, so the byte is presented combinationally.
  assign rx_byte_c   = {shift, MOSI};
  assign byte_done_c = rst_n && !SSEL && (bit_cnt == BIT_CNT_W'(BYTE_W - 1));

endmodule

// File: rtl/spi_cfg_regfile.sv
// SPI-slave configuration register bank with burst auto-increment writes,
// optional read-back on MISO and a one-cycle write strobe.
// Ports:
//   SCLK    : SPI clock, only clock        rst_n   : sync active-low reset
//   SSEL    : active-low chip select       MOSI    : serial in, MSB first
//   MISO    : serial out, MSB first        cfg_q   : flattened registers
//   wr_stb  : pulse after each write       wr_addr : index just written
// Build option: define SPI_CFG_READBACK_EN to enable the read path; without
// it MISO is tied low and read headers are ignored.
module spi_cfg_regfile
  import spi_cfg_pkg::*;
#(
  parameter int unsigned                    NUM_REGS  = 8,
  parameter int unsigned                    DATA_W    = 8,
  parameter logic [NUM_REGS*DATA_W-1:0]     RESET_VAL = '0
) (
  input  logic                       SCLK,
  input  logic                       rst_n,
  input  logic                       SSEL,
  input  logic                       MOSI,
  output logic                       MISO,
  output logic [NUM_REGS*DATA_W-1:0] cfg_q,
  output logic                       wr_stb,
  output logic [HDR_ADDR_W-1:0]      wr_addr
);

  logic [BYTE_W-1:0]     rx_byte_c;
  logic                  byte_done_c;
  frame_state_e          state;
  logic [HDR_ADDR_W-1:0] ptr;
  logic [HDR_ADDR_W-1:0] hdr_addr_c;
  logic                  hdr_rw_c;
  logic                  hdr_valid_c;

  spi_byte_rx u_rx (
    .SCLK        (SCLK),
    .rst_n       (rst_n),
    .SSEL        (SSEL),
    .MOSI        (MOSI),
    .rx_byte_c   (rx_byte_c),
    .byte_done_c (byte_done_c)
  );

  assign hdr_addr_c  = rx_byte_c[HDR_ADDR_LSB +: HDR_ADDR_W];
  assign hdr_rw_c    = rx_byte_c[HDR_RW_BIT];
  assign hdr_valid_c = 32'(hdr_addr_c) < NUM_REGS;

  // Frame FSM, address pointer, register array and write strobe.
  always_ff @(posedge SCLK) begin
    if (!rst_n) begin
      state   <= HDR;
      ptr     <= '0;
      cfg_q   <= RESET_VAL;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (SSEL) begin
        state <= HDR;
        ptr   <= '0;
      end else if (byte_done_c) begin
        case (state)
          HDR: begin
            ptr <= hdr_addr_c;
            if (!hdr_valid_c) begin
              state <= IGNORE;
            end else if (!hdr_rw_c) begin
              state <= WR;
            end else begin
`ifdef SPI_CFG_READBACK_EN
              // First read word is loaded now, so the pointer already moves past it.
              state <= RD;
              ptr   <= ptr_next(hdr_addr_c, NUM_REGS);
`else
              state <= IGNORE;
`endif
            end
          end
          WR: begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
              if (ptr == HDR_ADDR_W'(i)) begin
                cfg_q[i*DATA_W +: DATA_W] <= rx_byte_c[DATA_W-1:0];
              end
            end
            wr_stb  <= 1'b1;
            wr_addr <= ptr;
            ptr     <= ptr_next(ptr, NUM_REGS);
          end
          RD: begin
            ptr <= ptr_next(ptr, NUM_REGS);
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef SPI_CFG_READBACK_EN
  logic [BYTE_W-1:0]     tx;
  logic [HDR_ADDR_W-1:0] rd_idx_c;
  logic [DATA_W-1:0]     rd_val_c;

  // Register selected for the next tx load: header address or running pointer.
  always_comb begin
    rd_idx_c = (state == HDR) ? hdr_addr_c : ptr;
    rd_val_c = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (rd_idx_c == HDR_ADDR_W'(i)) begin
        rd_val_c = cfg_q[i*DATA_W +: DATA_W];
      end
    end
  end

  // Tx shifter: loads on read byte boundaries, otherwise shifts zeros in.
  always_ff @(posedge SCLK) begin
    if (!rst_n || SSEL) begin
      tx <= '0;
    end else if (byte_done_c) begin
      if ((state == HDR && hdr_valid_c && hdr_rw_c) || state == RD) begin
        tx <= BYTE_W'(rd_val_c);
      end else begin
        tx <= '0;
      end
    end else begin
      tx <= {tx[BYTE_W-2:0], 1'b0};
    end
  end

  assign MISO = tx[BYTE_W-1];
`else
  assign MISO = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cfg_regfile.sv
// Self-checking bench for spi_cfg_regfile (NUM_REGS=8, DATA_W=8).
// A frame-level model tracks register contents, strobes and the expected MISO
// stream; a negedge process compares the DUT against it every cycle.
// Expectations follow SPI_CFG_READBACK_EN when it is defined.
module tb_spi_cfg_regfile;

  localparam int unsigned NREGS = 8;
  localparam logic [63:0] RST_IMG = 64'h0000_0000_0000_000A;
`ifdef SPI_CFG_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif
  localparam int MW = 0, MR = 1, MI = 2;

  logic        SCLK = 1'b0;
  logic        rst_n, SSEL, MOSI;
  logic        MISO;
  logic [63:0] cfg_q;
  logic        wr_stb;
  logic [3:0]  wr_addr;

  spi_cfg_regfile #(.NUM_REGS(NREGS), .DATA_W(8), .RESET_VAL(RST_IMG)) dut (
    .SCLK(SCLK), .rst_n(rst_n), .SSEL(SSEL), .MOSI(MOSI),
    .MISO(MISO), .cfg_q(cfg_q), .wr_stb(wr_stb), .wr_addr(wr_addr)
  );

  always #5 SCLK = ~SCLK;

  // Model state
  logic [7:0]  mdl [NREGS];
  logic        exp_stb = 1'b0;
  logic        exp_miso = 1'b0;
  logic [3:0]  exp_addr = 4'd0;
  bit          chk_en = 1'b0;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          stb_cnt = 0;
  logic [31:0] miso_hist = '0;
  logic [11:0] addr_hist = '0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [63:0] flat();
    logic [63:0] f;
    for (int i = 0; i < int'(NREGS); i++) f[i*8 +: 8] = mdl[i];
    return f;
  endfunction

  // Per-cycle comparison plus MISO/strobe history for the literal checks.
  always @(negedge SCLK) begin
    if (chk_en) begin
      cmp("cfg_q", cfg_q, flat());
      cmp("wr_stb", 64'(wr_stb), 64'(exp_stb));
      cmp("miso", 64'(MISO), 64'(exp_miso));
      if (exp_stb) cmp("wr_addr", 64'(wr_addr), 64'(exp_addr));
    end
    miso_hist <= {miso_hist[30:0], MISO};
    if (wr_stb) begin
      stb_cnt   <= stb_cnt + 1;
      addr_hist <= {addr_hist[7:0], wr_addr};
    end
  end

  // One SCLK edge with the given inputs; model defaults applied after it.
  task automatic step(input logic s, input logic m, input logic r);
    SSEL = s; MOSI = m; rst_n = r;
    @(posedge SCLK);
    #1;
    exp_stb = 1'b0;
    if (!r) begin
      for (int i = 0; i < int'(NREGS); i++) mdl[i] = RST_IMG[i*8 +: 8];
      exp_miso = 1'b0;
      chk_en   = 1'b1;
    end else if (s) begin
      exp_miso = 1'b0;
    end
  endtask

  // Header, nb full data bytes from dat (MSB byte first), tail bits of the
  // following byte, then one deselected edge.
  task automatic frame(input logic [7:0] hdr, input logic [31:0] dat,
                       input int nb, input int tail);
    int addr, ptr, mode, nbits, nbytes;
    logic [7:0] txb, b;
    addr = int'(hdr[3:0]);
    if (addr >= int'(NREGS))  mode = MI;
    else if (!hdr[7])         mode = MW;
    else                      mode = READBACK ? MR : MI;
    for (int k = 0; k < 8; k++) step(1'b0, hdr[7-k], 1'b1);
    ptr = addr;
    txb = 8'h00;
    if (mode == MR) begin
      txb      = mdl[addr];
      ptr      = (addr + 1) % int'(NREGS);
      exp_miso = txb[7];
    end
    nbytes = nb + ((tail > 0) ? 1 : 0);
    for (int j = 0; j < nbytes; j++) begin
      b     = dat[31-8*j -: 8];
      nbits = (j < nb) ? 8 : tail;
      for (int k = 0; k < nbits; k++) begin
        step(1'b0, b[7-k], 1'b1);
        if (k < 7) begin
          if (mode == MR) exp_miso = txb[6-k];
        end else if (mode == MW) begin
          mdl[ptr] = b;
          exp_stb  = 1'b1;
          exp_addr = 4'(ptr);
          ptr      = (ptr + 1) % int'(NREGS);
        end else if (mode == MR) begin
          txb      = mdl[ptr];
          exp_miso = txb[7];
          ptr      = (ptr + 1) % int'(NREGS);
        end
      end
    end
    step(1'b1, 1'b0, 1'b1);
  endtask

  task automatic settle();
    @(negedge SCLK);
    #1;
  endtask

  initial begin
    int s0;
    logic [7:0] dat55;
    dat55 = 8'h55;
    SSEL = 1'b1; MOSI = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < int'(NREGS); i++) mdl[i] = 8'h00;

    // Reset held for two edges
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    settle();
    cmp("rst_cfg_lit", cfg_q, 64'h0000_0000_0000_000A);
    cmp("rst_miso_lit", 64'(MISO), 64'd0);
    cmp("rst_stb_lit", 64'(wr_stb), 64'd0);
    cmp("rst_addr_lit", 64'(wr_addr), 64'd0);

    // Single write: reg1 = 0x2A
    s0 = stb_cnt;
    frame(8'h01, 32'h2A00_0000, 1, 0);
    settle();
    cmp("w1_cfg_lit", cfg_q, 64'h0000_0000_0000_2A0A);
    cmp("w1_stbcnt_lit", 64'(stb_cnt - s0), 64'd1);
    cmp("w1_addr_lit", 64'(addr_hist[3:0]), 64'd1);

    // Burst with wrap: reg7, reg0, reg1
    s0 = stb_cnt;
    frame(8'h07, 32'h1122_3300, 3, 0);
    settle();
    cmp("wrap_cfg_lit", cfg_q, 64'h1100_0000_0000_3322);
    cmp("wrap_stbcnt_lit", 64'(stb_cnt - s0), 64'd3);
    cmp("wrap_addrs_lit", 64'(addr_hist), 64'h701);

    // Readback: reg2=C5, reg3=3C, then read from 2 with two dummy bytes
    frame(8'h02, 32'hC53C_0000, 2, 0);
    s0 = stb_cnt;
    frame(8'h82, 32'h0000_0000, 2, 0);
    settle();
    cmp("rd_byte0_lit", 64'(miso_hist[17:10]), READBACK ? 64'hC5 : 64'h00);
    cmp("rd_byte1_lit", 64'(miso_hist[9:2]), READBACK ? 64'h3C : 64'h00);
    cmp("rd_nostb_lit", 64'(stb_cnt - s0), 64'd0);
    cmp("rd_cfg_lit", cfg_q, 64'h1100_0000_3CC5_3322);

    // Abort after 5 data bits, then a clean write of reg0
    s0 = stb_cnt;
    frame(8'h00, 32'hFF00_0000, 0, 5);
    settle();
    cmp("abort_nostb_lit", 64'(stb_cnt - s0), 64'd0);
    cmp("abort_cfg_lit", cfg_q, 64'h1100_0000_3CC5_3322);
    frame(8'h00, 32'h7E00_0000, 1, 0);
    settle();
    cmp("abort_w_cfg_lit", cfg_q, 64'h1100_0000_3CC5_337E);
    cmp("abort_w_stb_lit", 64'(stb_cnt - s0), 64'd1);

    // Out-of-range start address
    s0 = stb_cnt;
    frame(8'h0C, 32'hFF00_0000, 1, 0);
    settle();
    cmp("oor_cfg_lit", cfg_q, 64'h1100_0000_3CC5_337E);
    cmp("oor_nostb_lit", 64'(stb_cnt - s0), 64'd0);
    cmp("oor_miso_lit", 64'(miso_hist[16:0]), 64'd0);

    // Reset lands on the completing edge of a write; next SSEL-low edge is a header bit
    s0 = stb_cnt;
    for (int k = 0; k < 8; k++) step(1'b0, (k >= 6) ? 1'b1 : 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) step(1'b0, dat55[7-k], 1'b1);
    step(1'b0, dat55[0], 1'b0);
    frame(8'h05, 32'h9900_0000, 1, 0);
    settle();
    cmp("rstwin_cfg_lit", cfg_q, 64'h0000_9900_0000_000A);
    cmp("rstwin_stb_lit", 64'(stb_cnt - s0), 64'd1);
    cmp("rstwin_addr_lit", 64'(addr_hist[3:0]), 64'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
